// File: rtl/debug_report_tx.sv
// Streams a debug report (PC, cycle count, register file, data memory) to a UART
// transmitter one byte at a time, least-significant byte of each word first.
module debug_report_tx #(
  parameter int unsigned BITS_SIZE     = 32,
  parameter int unsigned SIZE_TRAMA    = 8,
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned SIZE_MEM_DATA = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [BITS_SIZE-1:0]        i_mips_pc,
  input  logic [BITS_SIZE-1:0]        i_clk_wiz_count,
  input  logic [BITS_SIZE-1:0]        i_data_reg_file,
  input  logic [BITS_SIZE-1:0]        i_data_mem,
  input  logic                        i_uart_tx_done,
  output logic [$clog2(NUM_REGS)-1:0] o_select_register_dir,
  output logic [BITS_SIZE-1:0]        o_select_mem_dir,
  output logic [SIZE_TRAMA-1:0]       o_uart_tx_data,
  output logic                        o_flag_tx_ready,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int unsigned NUM_WORDS = 2 + NUM_REGS + SIZE_MEM_DATA;
  localparam int unsigned NUM_BYTES = BITS_SIZE / SIZE_TRAMA;
  localparam int unsigned MEM_BASE  = 2 + NUM_REGS;
  localparam int unsigned WORD_W    = $clog2(NUM_WORDS);
  localparam int unsigned BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned REG_W     = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_start;
  logic [BITS_SIZE-1:0]  r_snap_pc;
  logic [BITS_SIZE-1:0]  r_snap_cyc;
  logic [WORD_W-1:0]     r_word;
  logic [WORD_W-1:0]     w_word_next;
  logic [BYTE_W-1:0]     r_byte;
  logic [BITS_SIZE-1:0]  r_shift;
  logic [BITS_SIZE-1:0]  w_word_data;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_accept_start;
  logic                  w_sel_active;
  logic [REG_W-1:0]      w_sel_reg;
  logic [BITS_SIZE-1:0]  w_sel_mem;
  logic                  r_busy;
  logic                  r_tx_ready;
  logic                  r_done;
  logic [REG_W-1:0]      r_sel_reg;
  logic [BITS_SIZE-1:0]  r_sel_mem;

  // i_start is only honoured from a quiet IDLE; it arms r_start for one cycle.
  assign w_accept_start = (r_state == S_IDLE) && i_start && !r_start;

  // Next-state and word-index sequencing.
  always_comb begin
    w_state_next = r_state;
    w_word_next  = r_word;
    w_last_byte  = (r_byte == BYTE_W'(NUM_BYTES - 1));
    w_last_word  = (r_word == WORD_W'(NUM_WORDS - 1));
    case (r_state)
      S_IDLE: begin
        if (r_start) begin
          w_state_next = S_LOAD;
          w_word_next  = '0;
        end
      end
      S_LOAD: w_state_next = S_SEND;
      S_SEND: w_state_next = S_WAIT;
      S_WAIT: begin
        if (i_uart_tx_done) begin
          if (!w_last_byte) begin
            w_state_next = S_SEND;
          end else if (!w_last_word) begin
            w_state_next = S_LOAD;
            w_word_next  = r_word + WORD_W'(1);
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Source word for the current index; read data is valid while in LOAD.
  always_comb begin
    w_word_data = i_data_mem;
    if (r_word == '0) begin
      w_word_data = r_snap_pc;
    end else if (r_word == WORD_W'(1)) begin
      w_word_data = r_snap_cyc;
    end else if (r_word < WORD_W'(MEM_BASE)) begin
      w_word_data = i_data_reg_file;
    end
  end

  // Read selects follow the upcoming word index and idle at zero outside a report.
  always_comb begin
    w_sel_active = (w_state_next == S_LOAD) || (w_state_next == S_SEND) ||
                   (w_state_next == S_WAIT);
    w_sel_reg    = '0;
    w_sel_mem    = '0;
    if (w_sel_active && (w_word_next >= WORD_W'(2)) && (w_word_next < WORD_W'(MEM_BASE))) begin
      w_sel_reg = REG_W'(w_word_next - WORD_W'(2));
    end
    if (w_sel_active && (w_word_next >= WORD_W'(MEM_BASE))) begin
      w_sel_mem = BITS_SIZE'(w_word_next - WORD_W'(MEM_BASE));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_start    <= 1'b0;
      r_snap_pc  <= '0;
      r_snap_cyc <= '0;
      r_word     <= '0;
      r_byte     <= '0;
      r_shift    <= '0;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_done     <= 1'b0;
      r_sel_reg  <= '0;
      r_sel_mem  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_word     <= w_word_next;
      r_start    <= w_accept_start;
      if (w_accept_start) begin
        r_snap_pc  <= i_mips_pc;
        r_snap_cyc <= i_clk_wiz_count;
      end
      if (r_state == S_LOAD) begin
        r_shift <= w_word_data;
        r_byte  <= '0;
      end else if ((r_state == S_WAIT) && i_uart_tx_done && !w_last_byte) begin
        r_shift <= r_shift >> SIZE_TRAMA;
        r_byte  <= r_byte + BYTE_W'(1);
      end
      r_busy     <= (w_state_next != S_IDLE);
      r_tx_ready <= (w_state_next == S_SEND);
      r_done     <= (w_state_next == S_DONE);
      r_sel_reg  <= w_sel_reg;
      r_sel_mem  <= w_sel_mem;
    end
  end

  assign o_uart_tx_data        = r_shift[SIZE_TRAMA-1:0];
  assign o_flag_tx_ready       = r_tx_ready;
  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_select_register_dir = r_sel_reg;
  assign o_select_mem_dir      = r_sel_mem;

endmodule
